// File: rtl/shapool_job_ctrl.sv
// ---------------------------------------------------------------------------
// shapool_job_ctrl
//
// Job sequencer sitting in front of the shapool hashing pool. A job arrives on
// a valid/ready handshake, its fields are registered onto the pool inputs, and
// the pool is held in reset for one LOAD cycle so it starts from those fields.
// While the pool runs, a private round counter (rcnt) and iteration counter
// (win) mirror the pool's 64-cycle round cadence, so success and nonce-space
// exhaustion can be qualified without extra status from the pool. The outcome
// (FOUND / EXHAUSTED / ABORTED) is returned on a second valid/ready handshake.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   job_valid/job_ready     job handshake (ready only while idle)
//   job_*                   job fields, sampled on the job handshake
//   abort                   cancel the running job
//   pool_reset_n            active-low reset to the pool (released only in RUN)
//   pool_*  (out)           registered job fields driven to the pool
//   pool_success            pool success indication
//   pool_nonce              pool nonce_lower, zero-extended
//   pool_match_flags        per-pipeline match flags
//   busy                    high while loading or running
//   result_valid/ready      result handshake
//   result_status           01 FOUND, 10 EXHAUSTED, 11 ABORTED
//   result_nonce            reconstructed winning nonce (0 unless FOUND)
//   result_flags            match flags captured on success
// ---------------------------------------------------------------------------
module shapool_job_ctrl #(
    parameter int POOL_SIZE      = 2,
    parameter int POOL_SIZE_LOG2 = 1,
    parameter int ITER_WIDTH     = 32 - POOL_SIZE_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [255:0]          job_sha_state,
    input  logic [95:0]           job_message_head,
    input  logic [15:0]           job_difficulty_bm,
    input  logic [7:0]            job_nonce_start_MSB,

    input  logic                  abort,

    output logic                  pool_reset_n,
    output logic [255:0]          pool_sha_state,
    output logic [95:0]           pool_message_head,
    output logic [15:0]           pool_difficulty_bm,
    output logic [7:0]            pool_nonce_start_MSB,
    input  logic                  pool_success,
    input  logic [31:0]           pool_nonce,
    input  logic [POOL_SIZE-1:0]  pool_match_flags,

    output logic                  busy,

    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [1:0]            result_status,
    output logic [31:0]           result_nonce,
    output logic [POOL_SIZE-1:0]  result_flags
);

    localparam int WIN_W = ITER_WIDTH + 2;
    // Pipeline latency adds two iterations beyond the nonce space, so the
    // last meaningful success can only appear once win reaches 2^IW + 2.
    localparam logic [WIN_W-1:0] WIN_TERM = WIN_W'((64'd1 << ITER_WIDTH) + 64'd2);

    localparam logic [1:0] ST_FOUND     = 2'b01;
    localparam logic [1:0] ST_EXHAUSTED = 2'b10;
    localparam logic [1:0] ST_ABORTED   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_REPORT
    } state_t;

    state_t state, state_nxt;

    logic [5:0]       rcnt;
    logic [WIN_W-1:0] win;

    logic take_abort, take_found, take_exhaust;

    // ---------------------------------------------------------------------
    // Nonce reconstruction
    // ---------------------------------------------------------------------
    logic [ITER_WIDTH-1:0]     nonce_lo;
    logic [ITER_WIDTH-1:0]     msb_align;
    logic [POOL_SIZE_LOG2-1:0] upper;
    logic [31:0]               found_nonce;

    // The start MSB byte lines up with the top byte of nonce_lower; when the
    // nonce space is narrower than a byte only the byte's top bits apply.
    generate
        if (ITER_WIDTH >= 8) begin : g_msb_wide
            assign msb_align = ITER_WIDTH'(pool_nonce_start_MSB) << (ITER_WIDTH - 8);
        end else begin : g_msb_narrow
            assign msb_align = ITER_WIDTH'(pool_nonce_start_MSB >> (8 - ITER_WIDTH));
        end
    endgenerate

    // The pool has already stepped two nonces past the one that hit.
    assign nonce_lo = pool_nonce[ITER_WIDTH-1:0] - ITER_WIDTH'(2);

    // Lowest-index matching pipeline supplies the upper nonce bits.
    always_comb begin
        upper = '0;
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (pool_match_flags[i]) upper = POOL_SIZE_LOG2'(i);
        end
    end

    assign found_nonce = 32'({upper, nonce_lo ^ msb_align});

    logic unused_nonce_hi;
    assign unused_nonce_hi = ^pool_nonce[31:ITER_WIDTH];

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        take_abort   = 1'b0;
        take_found   = 1'b0;
        take_exhaust = 1'b0;
        job_ready    = 1'b0;
        busy         = 1'b0;
        pool_reset_n = 1'b0;
        result_valid = 1'b0;
        case (state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                busy         = 1'b1;
                pool_reset_n = 1'b1;
                // Successes before win reaches 2 come from the reset-flushed
                // pipeline and are not real results.
                if (abort) begin
                    take_abort = 1'b1;
                    state_nxt  = S_REPORT;
                end else if (pool_success && rcnt == 6'd0 && win >= WIN_W'(2)) begin
                    take_found = 1'b1;
                    state_nxt  = S_REPORT;
                end else if (rcnt == 6'd0 && win == WIN_TERM) begin
                    take_exhaust = 1'b1;
                    state_nxt    = S_REPORT;
                end
            end
            S_REPORT: begin
                result_valid = 1'b1;
                if (result_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pool_sha_state       <= '0;
            pool_message_head    <= '0;
            pool_difficulty_bm   <= '0;
            pool_nonce_start_MSB <= '0;
            rcnt                 <= '0;
            win                  <= '0;
            result_status        <= '0;
            result_nonce         <= '0;
            result_flags         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        pool_sha_state       <= job_sha_state;
                        pool_message_head    <= job_message_head;
                        pool_difficulty_bm   <= job_difficulty_bm;
                        pool_nonce_start_MSB <= job_nonce_start_MSB;
                        rcnt                 <= '0;
                        win                  <= '0;
                    end
                end
                S_RUN: begin
                    rcnt <= rcnt + 6'd1;
                    // Saturate: the terminal value always forces an exit.
                    if (rcnt == 6'd63 && win != WIN_TERM) win <= win + WIN_W'(1);
                    if (take_abort) begin
                        result_status <= ST_ABORTED;
                        result_nonce  <= '0;
                        result_flags  <= '0;
                    end else if (take_found) begin
                        result_status <= ST_FOUND;
                        result_nonce  <= found_nonce;
                        result_flags  <= pool_match_flags;
                    end else if (take_exhaust) begin
                        result_status <= ST_EXHAUSTED;
                        result_nonce  <= '0;
                        result_flags  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shapool_job_ctrl.sv
module tb_shapool_job_ctrl;
    localparam int PS   = 2;
    localparam int PSL  = 1;
    localparam int IW   = 3;
    localparam int TERM = (1 << IW) + 2;   // terminal iteration count

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [255:0]  job_sha_state = '0;
    logic [95:0]   job_message_head = '0;
    logic [15:0]   job_difficulty_bm = '0;
    logic [7:0]    job_nonce_start_MSB = '0;
    logic          abort = 1'b0;
    logic          pool_reset_n;
    logic [255:0]  pool_sha_state;
    logic [95:0]   pool_message_head;
    logic [15:0]   pool_difficulty_bm;
    logic [7:0]    pool_nonce_start_MSB;
    logic          pool_success = 1'b0;
    logic [31:0]   pool_nonce = '0;
    logic [PS-1:0] pool_match_flags = '0;
    logic          busy;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [1:0]    result_status;
    logic [31:0]   result_nonce;
    logic [PS-1:0] result_flags;

    shapool_job_ctrl #(.POOL_SIZE(PS), .POOL_SIZE_LOG2(PSL), .ITER_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_sha_state(job_sha_state), .job_message_head(job_message_head),
        .job_difficulty_bm(job_difficulty_bm), .job_nonce_start_MSB(job_nonce_start_MSB),
        .abort(abort),
        .pool_reset_n(pool_reset_n), .pool_sha_state(pool_sha_state),
        .pool_message_head(pool_message_head), .pool_difficulty_bm(pool_difficulty_bm),
        .pool_nonce_start_MSB(pool_nonce_start_MSB),
        .pool_success(pool_success), .pool_nonce(pool_nonce), .pool_match_flags(pool_match_flags),
        .busy(busy),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_status(result_status), .result_nonce(result_nonce), .result_flags(result_flags)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 load, 2 run, 3 report. m_k counts cycles since RUN entry;
    // round position and iteration follow from it by plain division.
    int            m_phase = 0;
    int            m_k = 0;
    logic [255:0]  m_sha = '0;
    logic [95:0]   m_head = '0;
    logic [15:0]   m_diff = '0;
    logic [7:0]    m_msb = '0;
    logic [1:0]    m_status = '0;
    logic [31:0]   m_nonce = '0;
    logic [PS-1:0] m_flags = '0;

    function automatic logic [31:0] model_nonce(input logic [31:0] pn, input logic [7:0] msb,
                                                input logic [PS-1:0] fl);
        logic [31:0] l;
        int up;
        l = (pn + 32'hFFFF_FFFE) % (32'd1 << IW);          // back up two nonces
        l = l ^ (({msb, 24'h0}) >> (32 - IW));             // msb byte on top of nonce_lower
        up = 0;
        for (int i = 0; i < PS; i++) begin
            if (fl[i]) begin up = i; break; end
        end
        return (32'(up) << IW) | l;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0; m_k <= 0;
            m_sha <= '0; m_head <= '0; m_diff <= '0; m_msb <= '0;
            m_status <= '0; m_nonce <= '0; m_flags <= '0;
        end else begin
            case (m_phase)
                0: if (job_valid) begin
                    m_phase <= 1;
                    m_sha <= job_sha_state; m_head <= job_message_head;
                    m_diff <= job_difficulty_bm; m_msb <= job_nonce_start_MSB;
                end
                1: begin m_phase <= 2; m_k <= 0; end
                2: begin
                    if (abort) begin
                        m_phase <= 3; m_status <= 2'b11; m_nonce <= '0; m_flags <= '0;
                    end else if (pool_success && (m_k % 64) == 0 && (m_k / 64) >= 2) begin
                        m_phase <= 3; m_status <= 2'b01;
                        m_nonce <= model_nonce(pool_nonce, m_msb, pool_match_flags);
                        m_flags <= pool_match_flags;
                    end else if (m_k == 64 * TERM) begin
                        m_phase <= 3; m_status <= 2'b10; m_nonce <= '0; m_flags <= '0;
                    end else begin
                        m_k <= m_k + 1;
                    end
                end
                default: if (result_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("job_ready", job_ready, m_phase == 0);
            chk("busy", busy, m_phase == 1 || m_phase == 2);
            chk("pool_reset_n", pool_reset_n, m_phase == 2);
            chk("result_valid", result_valid, m_phase == 3);
            chk("pool_sha_state", pool_sha_state, m_sha);
            chk("pool_message_head", pool_message_head, m_head);
            chk("pool_difficulty_bm", pool_difficulty_bm, m_diff);
            chk("pool_nonce_start_MSB", pool_nonce_start_MSB, m_msb);
            if (m_phase == 3) begin
                chk("result_status", result_status, m_status);
                chk("result_nonce", result_nonce, m_nonce);
                chk("result_flags", result_flags, m_flags);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Leaves the bench positioned in RUN cycle 0.
    task automatic send_job(input logic [7:0] msb, input logic [255:0] sha);
        chk("lit idle job_ready", job_ready, 1'b1);
        job_sha_state = sha; job_message_head = sha[95:0] ^ 96'h1;
        job_difficulty_bm = sha[15:0] ^ 16'h8000; job_nonce_start_MSB = msb;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        chk("lit load pool_reset_n", pool_reset_n, 1'b0);
        chk("lit load busy", busy, 1'b1);
        chk("lit load fields", pool_sha_state, sha);
        tick();
    endtask

    task automatic take_result();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("lit after accept job_ready", job_ready, 1'b1);
    endtask

    initial begin
        tick();
        started = 1'b1;
        tick();
        reset = 1'b0;
        chk("lit reset job_ready", job_ready, 1'b1);
        chk("lit reset pool_reset_n", pool_reset_n, 1'b0);
        chk("lit reset result_valid", result_valid, 1'b0);
        chk("lit reset pool_sha", pool_sha_state, 256'h0);

        // abort / result_ready in IDLE have no effect
        abort = 1'b1; result_ready = 1'b1;
        tick(2);
        abort = 1'b0; result_ready = 1'b0;

        // FOUND at win 4
        send_job(8'h00, {8{32'hA5A5_0001}});
        tick(256);
        pool_success = 1'b1; pool_nonce = 32'd6; pool_match_flags = 2'b10;
        tick();
        pool_success = 1'b0;
        chk("lit found status", result_status, 2'b01);
        chk("lit found nonce", result_nonce, 32'h0000_000C);
        chk("lit found flags", result_flags, 2'b10);
        take_result();

        // exhaustion at RUN cycle 640
        send_job(8'h5A, {8{32'h1234_5678}});
        tick(640);
        chk("lit exh cycle640 busy", busy, 1'b1);
        chk("lit exh cycle640 result_valid", result_valid, 1'b0);
        tick();
        chk("lit exh status", result_status, 2'b10);
        chk("lit exh nonce", result_nonce, 32'h0);
        take_result();

        // stale success at win 1 ignored, then valid success at win 2
        send_job(8'h00, {8{32'hDEAD_BEEF}});
        tick(64);
        pool_success = 1'b1; pool_nonce = 32'd5; pool_match_flags = 2'b01;
        tick();
        chk("lit stale still busy", busy, 1'b1);
        tick();
        pool_success = 1'b0;
        tick(62);
        pool_success = 1'b1; pool_nonce = 32'd0; pool_match_flags = 2'b11;
        tick();
        pool_success = 1'b0;
        chk("lit stale-then-valid status", result_status, 2'b01);
        chk("lit wrapped nonce", result_nonce, 32'd6);
        take_result();

        // success exactly at the exhaustion boundary wins
        send_job(8'h00, {8{32'h0F0F_0F0F}});
        tick(640);
        pool_success = 1'b1; pool_nonce = 32'd3; pool_match_flags = 2'b01;
        tick();
        pool_success = 1'b0;
        chk("lit boundary status", result_status, 2'b01);
        chk("lit boundary nonce", result_nonce, 32'd1);
        take_result();

        // abort at RUN cycle 100 alongside success; result held while not ready
        send_job(8'hC3, {8{32'hCAFE_F00D}});
        tick(100);
        abort = 1'b1; pool_success = 1'b1; pool_nonce = 32'd7; pool_match_flags = 2'b11;
        chk("lit abort cycle100 pool_reset_n", pool_reset_n, 1'b1);
        tick();
        abort = 1'b0;
        chk("lit abort cycle101 pool_reset_n", pool_reset_n, 1'b0);
        repeat (5) begin
            pool_nonce = pool_nonce + 32'd1;
            tick();
            chk("lit hold status", result_status, 2'b11);
            chk("lit hold valid", result_valid, 1'b1);
            chk("lit hold nonce", result_nonce, 32'h0);
        end
        pool_success = 1'b0;
        take_result();

        // back-to-back: abort over a qualifying success, next job waiting
        send_job(8'h11, {8{32'h0BAD_CAFE}});
        tick(192);
        abort = 1'b1; pool_success = 1'b1; pool_nonce = 32'd2; pool_match_flags = 2'b01;
        result_ready = 1'b1; job_valid = 1'b1;
        job_sha_state = {8{32'h7777_1111}}; job_nonce_start_MSB = 8'h22;
        tick();
        abort = 1'b0; pool_success = 1'b0;
        chk("lit b2b status", result_status, 2'b11);
        tick();
        chk("lit b2b idle", job_ready, 1'b1);
        tick();
        chk("lit b2b load pool_reset_n", pool_reset_n, 1'b0);
        chk("lit b2b load sha", pool_sha_state, {8{32'h7777_1111}});
        chk("lit b2b load msb", pool_nonce_start_MSB, 8'h22);
        tick();
        chk("lit b2b run pool_reset_n", pool_reset_n, 1'b1);
        tick(3);
        job_valid = 1'b0; result_ready = 1'b0;

        // reset mid-RUN
        tick(10);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("lit rst job_ready", job_ready, 1'b1);
        chk("lit rst busy", busy, 1'b0);
        chk("lit rst pool_reset_n", pool_reset_n, 1'b0);
        chk("lit rst result_valid", result_valid, 1'b0);
        chk("lit rst msb", pool_nonce_start_MSB, 8'h00);

        // reset discards a pending result
        send_job(8'h33, {8{32'h5555_AAAA}});
        tick(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("lit pending valid", result_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("lit pending dropped", result_valid, 1'b0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
